// File: rtl/hazard_pkg.sv
// Shared types for the hazard unit: forwarding selects, memory-wait states, register zero.
// Latency: n/a (types only). Backpressure: n/a.
package hazard_pkg;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;
  localparam fwd_sel_t FWD_W  = 2'b01;
  localparam fwd_sel_t FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RELEASE
  } mem_wait_state_t;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// One Execute-stage forwarding channel; Memory result beats Writeback, register zero never forwards.
// Latency: combinational. Backpressure: none.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rsE,
  input  logic [REG_ADDR_W-1:0] rdM,
  input  logic [REG_ADDR_W-1:0] rdW,
  input  logic                  regWriteM,
  input  logic                  regWriteW,
  output fwd_sel_t              fwdSel
);

  localparam logic [REG_ADDR_W-1:0] RegZero = REG_ADDR_W'(REG_ZERO);

  always_comb begin
    fwdSel = FWD_RF;
    if (regWriteM && (rdM == rsE) && (rdM != RegZero)) begin
      fwdSel = FWD_M;
    end else if (regWriteW && (rdW == rsE) && (rdW != RegZero)) begin
      fwdSel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: forwarding, load-use stall, branch flush, memory-wait freeze, perf counters.
// Latency: stall/flush/forward outputs combinational; FSM and counters registered. Backpressure: drives stage stalls.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MEM_LAT    = 1,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_d,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_e,
  input  logic [REG_ADDR_W-1:0]         rd_e,
  input  logic [REG_ADDR_W-1:0]         rd_m,
  input  logic [REG_ADDR_W-1:0]         rd_w,
  input  logic                          reg_write_e,
  input  logic                          reg_write_m,
  input  logic                          reg_write_w,
  input  logic                          result_src_e,
  input  logic                          pc_src_e,
  input  logic                          mem_req_m,
  output logic [NUM_SRC*2-1:0]          forward_e,
  output logic                          stall_f,
  output logic                          stall_d,
  output logic                          stall_e,
  output logic                          stall_m,
  output logic                          flush_d,
  output logic                          flush_e,
  output logic                          flush_w,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              flush_cnt
);

  localparam logic [3:0]            LoadCnt = 4'(MEM_LAT - 2);
  localparam logic [REG_ADDR_W-1:0] RegZero = REG_ADDR_W'(REG_ZERO);

  mem_wait_state_t state, stateNext;
  logic [3:0]      cnt, cntNext;
  logic            memStall;
  logic            stallAll;
  logic            srcHit;
  logic            loadUse;
  fwd_sel_t        chSel [NUM_SRC];

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : gFwd
      fwd_select #(
        .REG_ADDR_W(REG_ADDR_W)
      ) uFwd (
        .rsE       (rs_e[i*REG_ADDR_W +: REG_ADDR_W]),
        .rdM       (rd_m),
        .rdW       (rd_w),
        .regWriteM (reg_write_m),
        .regWriteW (reg_write_w),
        .fwdSel    (chSel[i])
      );
      assign forward_e[2*i +: 2] = reset ? chSel[i] : FWD_RF;
    end
  endgenerate

  // The first stalled cycle is spent in IDLE, so cnt only covers the remaining MEM_LAT-2 cycles.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    memStall  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req_m && (MEM_LAT > 1)) begin
          memStall  = 1'b1;
          cntNext   = LoadCnt;
          stateNext = (MEM_LAT > 2) ? WAIT : RELEASE;
        end
      end
      WAIT: begin
        memStall = 1'b1;
        if (cnt == 4'd1) begin
          stateNext = RELEASE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      RELEASE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_comb begin
    srcHit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (rs_d[i*REG_ADDR_W +: REG_ADDR_W] == rd_e) begin
        srcHit = 1'b1;
      end
    end
  end

  assign stallAll = reset & memStall;
  assign loadUse  = result_src_e & reg_write_e & (rd_e != RegZero) & srcHit;

  // A taken branch squashes the dependent instruction, so it overrides the load-use hold.
  assign stall_f = reset & (stallAll | (loadUse & ~pc_src_e));
  assign stall_d = stall_f;
  assign stall_e = stallAll;
  assign stall_m = stallAll;
  assign flush_w = stallAll;
  assign flush_d = reset & ~stallAll & pc_src_e;
  assign flush_e = reset & ~stallAll & (pc_src_e | loadUse);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if ((flush_d || flush_e) && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (MEM_LAT 1/4/2) share stimulus and are checked
// every cycle against a cycle-count reference model, plus directed scenario checks.
module tb_hazard_ctrl;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NS*AW-1:0] rsD, rsE;
  logic [AW-1:0] rdE, rdM, rdW;
  logic          rwE, rwM, rwW, resSrcE, pcSrcE, memReqM;

  logic [2*NS-1:0] obsFwd      [NI];
  logic [3:0]      obsStall    [NI];
  logic [2:0]      obsFlush    [NI];
  logic [15:0]     obsStallCnt [NI];
  logic [15:0]     obsFlushCnt [NI];

  generate
    for (genvar g = 0; g < NI; g++) begin : gDut
      localparam int LATG = (g == 1) ? 4 : ((g == 2) ? 2 : 1);
      localparam int CW   = (g == 1) ? 4 : 16;
      logic [CW-1:0] sc, fc;
      logic sf, sd, se, sm, fd, fe, fw;
      hazard_ctrl #(
        .REG_ADDR_W(AW), .NUM_SRC(NS), .MEM_LAT(LATG), .CNT_W(CW)
      ) dut (
        .clk(clk), .reset(rst), .rs_d(rsD), .rs_e(rsE),
        .rd_e(rdE), .rd_m(rdM), .rd_w(rdW),
        .reg_write_e(rwE), .reg_write_m(rwM), .reg_write_w(rwW),
        .result_src_e(resSrcE), .pc_src_e(pcSrcE), .mem_req_m(memReqM),
        .forward_e(obsFwd[g]),
        .stall_f(sf), .stall_d(sd), .stall_e(se), .stall_m(sm),
        .flush_d(fd), .flush_e(fe), .flush_w(fw),
        .stall_cnt(sc), .flush_cnt(fc)
      );
      assign obsStall[g]    = {sf, sd, se, sm};
      assign obsFlush[g]    = {fd, fe, fw};
      assign obsStallCnt[g] = 16'(sc);
      assign obsFlushCnt[g] = 16'(fc);
    end
  endgenerate

  int numChecks = 0;
  int numFails  = 0;

  // Reference model: remaining stall cycles, a release flag and plain integer counters.
  int mRem [NI];
  bit mRel [NI];
  int mSc  [NI];
  int mFc  [NI];
  bit eSF  [NI];
  bit eFl  [NI];

  function automatic int latOf(input int k);
    return (k == 1) ? 4 : ((k == 2) ? 2 : 1);
  endfunction

  function automatic int cntMaxOf(input int k);
    return (k == 1) ? 15 : 65535;
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    bit lu, hit, sa, sF, fD, fE;
    logic [2*NS-1:0] f;
    int rs, ch;
    #1;
    hit = 1'b0;
    f   = '0;
    for (int i = 0; i < NS; i++) begin
      if (int'(rsD[i*AW +: AW]) == int'(rdE)) hit = 1'b1;
      rs = int'(rsE[i*AW +: AW]);
      if (rwM && int'(rdM) == rs && rdM != 0)      ch = 2;
      else if (rwW && int'(rdW) == rs && rdW != 0) ch = 1;
      else                                         ch = 0;
      f[2*i +: 2] = 2'(ch);
    end
    lu = rwE && resSrcE && (rdE != 0) && hit;
    for (int k = 0; k < NI; k++) begin
      sa = rst && (mRem[k] > 0 || (!mRel[k] && memReqM && latOf(k) > 1));
      sF = rst && (sa || (lu && !pcSrcE));
      fD = rst && !sa && pcSrcE;
      fE = rst && !sa && (pcSrcE || lu);
      eSF[k] = sF;
      eFl[k] = fD || fE;
      checkVal($sformatf("u%0d_fwd", k), 32'(obsFwd[k]), rst ? 32'(f) : 32'd0);
      checkVal($sformatf("u%0d_stall", k), 32'(obsStall[k]), 32'({sF, sF, sa, sa}));
      checkVal($sformatf("u%0d_flush", k), 32'(obsFlush[k]), 32'({fD, fE, sa}));
      checkVal($sformatf("u%0d_stall_cnt", k), 32'(obsStallCnt[k]), 32'(mSc[k]));
      checkVal($sformatf("u%0d_flush_cnt", k), 32'(obsFlushCnt[k]), 32'(mFc[k]));
    end
  endtask

  task automatic advance();
    for (int k = 0; k < NI; k++) begin
      if (!rst) begin
        mRem[k] = 0; mRel[k] = 1'b0; mSc[k] = 0; mFc[k] = 0;
      end else begin
        if (eSF[k] && mSc[k] < cntMaxOf(k)) mSc[k]++;
        if (eFl[k] && mFc[k] < cntMaxOf(k)) mFc[k]++;
        if (mRem[k] > 0) begin
          mRem[k]--;
          if (mRem[k] == 0) mRel[k] = 1'b1;
        end else if (mRel[k]) begin
          mRel[k] = 1'b0;
        end else if (memReqM && latOf(k) > 1) begin
          mRem[k] = latOf(k) - 2;
          if (mRem[k] == 0) mRel[k] = 1'b1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rsD = '0; rsE = '0; rdE = '0; rdM = '0; rdW = '0;
    rwE = 0; rwM = 0; rwW = 0; resSrcE = 0; pcSrcE = 0; memReqM = 0;
  endtask

  task automatic doReset();
    rst = 1'b0;
    clearInputs();
    settle();
    advance();
    rst = 1'b1;
  endtask

  task automatic setLoadUse();
    resSrcE = 1; rwE = 1; rdE = 5'd7; rsD = {5'd7, 5'd0};
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      mRem[k] = 0; mRel[k] = 0; mSc[k] = 0; mFc[k] = 0; eSF[k] = 0; eFl[k] = 0;
    end
    rst = 1'b0;
    clearInputs();
    @(posedge clk);
    @(negedge clk);
    doReset();

    // Forwarding priority
    rsE = {5'd0, 5'd3}; rdM = 5'd3; rdW = 5'd3; rwM = 1; rwW = 1;
    settle(); checkVal("dir_fwd_mem", 32'(obsFwd[0][1:0]), 32'h2); advance();
    rwM = 0;
    settle(); checkVal("dir_fwd_wb", 32'(obsFwd[0][1:0]), 32'h1); advance();
    rsE = {5'd0, 5'd0};
    settle(); checkVal("dir_fwd_zero", 32'(obsFwd[0][1:0]), 32'h0); advance();

    // Load-use
    clearInputs(); setLoadUse();
    settle();
    checkVal("dir_lu_stall", 32'(obsStall[0]), 32'hC);
    checkVal("dir_lu_flush", 32'(obsFlush[0]), 32'h2);
    advance();
    clearInputs();
    settle(); checkVal("dir_lu_cnt", 32'(obsStallCnt[0]), 32'd1); advance();

    // Branch overriding load-use
    setLoadUse(); pcSrcE = 1;
    settle();
    checkVal("dir_br_stall", 32'(obsStall[0]), 32'h0);
    checkVal("dir_br_flush", 32'(obsFlush[0]), 32'h6);
    advance();
    clearInputs();
    settle(); checkVal("dir_br_flush_cnt", 32'(obsFlushCnt[0]), 32'd2); advance();

    // MEM_LAT = 4 single access, request held through the release cycle
    doReset();
    memReqM = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkVal($sformatf("dir_lat4_stall%0d", i), 32'(obsStall[1]), 32'hF);
      checkVal($sformatf("dir_lat4_flushw%0d", i), 32'(obsFlush[1]), 32'h1);
      advance();
    end
    settle(); checkVal("dir_lat4_release", 32'(obsStall[1]), 32'h0); advance();
    memReqM = 0;
    settle(); checkVal("dir_lat4_cnt", 32'(obsStallCnt[1]), 32'd3); advance();

    // MEM_LAT = 2 back-to-back with a branch held throughout
    doReset();
    memReqM = 1; pcSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      settle();
      checkVal($sformatf("dir_lat2_stallf%0d", i), 32'(obsStall[2][3]), 32'((i % 2) == 0));
      checkVal($sformatf("dir_lat2_flushd%0d", i), 32'(obsFlush[2][2]), 32'((i % 2) == 1));
      advance();
    end
    clearInputs();

    // Reset in the middle of a wait, then counter saturation
    doReset();
    memReqM = 1;
    settle(); advance();
    memReqM = 0;
    settle(); checkVal("dir_wait_stall", 32'(obsStall[1]), 32'hF); advance();
    rst = 1'b0;
    settle();
    checkVal("dir_rst_stall", 32'(obsStall[1]), 32'h0);
    checkVal("dir_rst_flush", 32'(obsFlush[1]), 32'h0);
    advance();
    rst = 1'b1;
    settle();
    checkVal("dir_post_rst_stall", 32'(obsStall[1]), 32'h0);
    checkVal("dir_post_rst_cnt", 32'(obsStallCnt[1]), 32'd0);
    advance();
    setLoadUse();
    for (int i = 0; i < 20; i++) begin
      settle(); advance();
    end
    clearInputs();
    settle(); checkVal("dir_sat_cnt", 32'(obsStallCnt[1]), 32'd15); advance();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst     = ($urandom_range(0, 99) != 0);
      rsD     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rsE     = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      rdE     = 5'($urandom_range(0, 3));
      rdM     = 5'($urandom_range(0, 3));
      rdW     = 5'($urandom_range(0, 3));
      rwE     = 1'($urandom_range(0, 1));
      rwM     = 1'($urandom_range(0, 1));
      rwW     = 1'($urandom_range(0, 1));
      resSrcE = 1'($urandom_range(0, 1));
      pcSrcE  = ($urandom_range(0, 3) == 0);
      memReqM = ($urandom_range(0, 3) == 0);
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
